// File: rtl/proc_param.sv
// Parametrised multi-cycle processor: shared bus, register file, accumulator A,
// result register G, zero/carry flags and a four-step T0..T3 controller.
module proc_param #(
    parameter int W     = 16,
    parameter int RBITS = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [W-1:0] DIN,
    output logic         Done,
    output logic [W-1:0] BusWires,
    output logic [1:0]   Tstep_Q,
    output logic [W-1:0] Q,
    output logic         Zflag,
    output logic         Cflag
);

    localparam int NREG    = 2**RBITS;
    localparam int IRW     = 3 + 2*RBITS;
    localparam int SRC_G   = NREG;
    localparam int SRC_DIN = NREG + 1;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_t;

    tstep_t          tstep, tstep_next;
    logic [IRW-1:0]  ir;
    logic [2:0]      op;
    logic [RBITS-1:0] rx, ry;
    logic [W-1:0]    regs [NREG];
    logic [W-1:0]    a, g;
    logic [W:0]      alu_out;

    logic            ir_in, a_in, g_in, done;
    logic [NREG-1:0] rin;
    logic [NREG+1:0] src_sel;

    assign op = ir[IRW-1 -: 3];
    assign rx = ir[2*RBITS-1:RBITS];
    assign ry = ir[RBITS-1:0];

    // Bit W of the result carries the carry-out; subtraction is A + ~B + 1.
    function automatic logic [W:0] alu(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        case (f)
            OP_ADD:  alu = {1'b0, x} + {1'b0, y};
            OP_SUB:  alu = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            OP_AND:  alu = {1'b0, x & y};
            OP_XOR:  alu = {1'b0, x ^ y};
            default: alu = '0;
        endcase
    endfunction

    always_comb begin
        tstep_next = tstep;
        ir_in      = 1'b0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        done       = 1'b0;
        rin        = '0;
        src_sel    = '0;
        case (tstep)
            T0: begin
                if (Run) begin
                    ir_in      = 1'b1;
                    tstep_next = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        src_sel[ry] = 1'b1;
                        rin[rx]     = 1'b1;
                        done        = 1'b1;
                    end
                    OP_MVI: begin
                        src_sel[SRC_DIN] = 1'b1;
                        rin[rx]          = 1'b1;
                        done             = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                        src_sel[rx] = 1'b1;
                        a_in        = 1'b1;
                        tstep_next  = T2;
                    end
                    OP_MVNZ: begin
                        src_sel[ry] = 1'b1;
                        rin[rx]     = !Zflag;
                        done        = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                src_sel[ry] = 1'b1;
                g_in        = 1'b1;
                tstep_next  = T3;
            end
            T3: begin
                src_sel[SRC_G] = 1'b1;
                rin[rx]        = 1'b1;
                done           = 1'b1;
            end
            default: tstep_next = T0;
        endcase
        if (done) tstep_next = T0;
    end

    // One-hot bus: OR of every selected source, zero when idle.
    always_comb begin
        BusWires = '0;
        for (int k = 0; k < NREG; k++)
            if (src_sel[k]) BusWires = BusWires | regs[k];
        if (src_sel[SRC_G])   BusWires = BusWires | g;
        if (src_sel[SRC_DIN]) BusWires = BusWires | DIN;
    end

    assign alu_out = alu(op, a, BusWires);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tstep <= T0;
            ir    <= '0;
            a     <= '0;
            g     <= '0;
            Zflag <= 1'b0;
            Cflag <= 1'b0;
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            tstep <= tstep_next;
            if (ir_in) ir <= DIN[W-1 -: IRW];
            if (a_in)  a  <= BusWires;
            if (g_in) begin
                g     <= alu_out[W-1:0];
                Zflag <= (alu_out[W-1:0] == '0);
                Cflag <= alu_out[W];
            end
            for (int k = 0; k < NREG; k++)
                if (rin[k]) regs[k] <= BusWires;
        end
    end

    assign Done    = done;
    assign Tstep_Q = tstep;
    assign Q       = regs[0];

endmodule

// File: doc/proc_param.md
# proc_param

Parametrised multi-cycle processor datapath and control: a shared bus, a general-purpose register file, accumulator A, result register G and a 4-step controller. It extends the 16-bit, 8-register mv/mvi/add/sub core in three ways: data width and register count are generic; the instruction set adds logic ops and a conditional move; zero and carry flags are kept. It sits behind the instruction/data source that drives DIN and Run.

## Interface
- W, 16, data and bus width in bits; requires W >= 3 + 2*RBITS
- RBITS, 3, register-select field width; register count NREG = 2^RBITS

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  one clock; reset is synchronous and active-high.
- Run  in  1  start request, sampled in T0.
- DIN  in  W  instruction word in T0; immediate operand in T1 for mvi.
- Done  out  1  high during the final step of each instruction.
- BusWires  out  W  current bus value.
- Tstep_Q  out  2  current step: 0=T0, 1=T1, 2=T2, 3=T3.
- Q  out  W  contents of R0, for debug and LEDs.
- Zflag  out  1  zero flag.
- Cflag  out  1  carry flag.

## Operation
- IR width is IRW = 3 + 2*RBITS. IR is loaded from DIN[W-1 -: IRW].
- IR field layout: I = IR[IRW-1 -: 3]; X = IR[2*RBITS-1 : RBITS]; Y = IR[RBITS-1 : 0].
- Bus source is one-hot, chosen from {R0..R(NREG-1), G, DIN}. When no source is selected, BusWires = 0.
- ALU: a W-bit adder/subtracter plus bitwise logic on A and BusWires. Subtract is A + ~Bus + 1. All results are modulo 2^W.
- Opcodes:
  - 000 mv: Rx <- Ry. Takes T1 only.
  - 001 mvi: Rx <- DIN. Takes T1 only.
  - 010 add: A <- Rx in T1; G <- A + Ry in T2, flags updated; Rx <- G in T3.
  - 011 sub: same steps as add, with G <- A - Ry.
  - 100 and: same steps as add, with G <- A & Ry.
  - 101 xor: same steps as add, with G <- A ^ Ry.
  - 110 mvnz: in T1, Rx <- Ry if Zflag = 0; otherwise no write. Done in T1 either way.
  - 111 reserved: no register or flag write. Done in T1.
- Flags are written only in T2 of opcodes 010-101.
  - Zflag = (G_next == 0).
  - For add, Cflag = carry-out of bit W-1.
  - For sub, Cflag = carry-out of A + ~Ry + 1, so 1 means no borrow, i.e. A >= Ry unsigned.
  - For and/xor, Cflag = 0.
- X == Y is legal: the operand is read before the write-back step.

## Timing
- Reset is synchronous and takes priority over every other action. On the next edge:
  - All Rk, A, G, IR, Zflag, Cflag and Tstep_Q are cleared to 0.
  - Outputs after reset: Done = 0, BusWires = 0, Q = 0, Zflag = 0, Cflag = 0, Tstep_Q = 0.
- Reset asserted mid-instruction aborts the instruction. No partial write-back occurs after that edge.
- T0 behaviour:
  - If Run = 1: IR <- DIN and Tstep advances to T1.
  - If Run = 0: stay in T0; Done = 0, no register enables, bus idle.
- Tstep advances by 1 each cycle. On the edge where Done = 1, it returns to T0.
- Latency from the Run edge to the write-back edge (inclusive):
  - mv, mvi, mvnz, reserved: 2 cycles.
  - ALU ops: 4 cycles.
- Back-to-back operation: if Run is held high, the next instruction is fetched in the cycle right after Done. There are no bubbles.
- Run is ignored outside T0.
- Done is a combinational decode of Tstep_Q and I. It is high for exactly one cycle per instruction and is never high in T0.
- Register write enables are combinational from the step and IR. The write takes effect on the edge that ends that step.
- DIN for mvi must be stable through T1. DIN is ignored in T2 and T3.

## Test plan
- Reset and idle: assert Reset mid-add at T2 with W=16. Next cycle: Tstep_Q=0, Q=0, Zflag=0, Cflag=0, Done=0. Then hold Run=0 for 5 cycles: Tstep stays 0, Done stays 0.
- mvi/mv: run mvi R0 with DIN=0x1234, then mv R3,R0. Required: Done pulses at T1 of each instruction; R3=0x1234; 2 cycles per instruction.
- Arithmetic and flags:
  - R1=0xFFFF, R2=0x0001, add R1,R2: R1=0x0000, Z=1, C=1; Done only in T3.
  - Then sub R2,R2: R2=0x0000, Z=1, C=1.
  - Then 0x0003 - 0x0005: result 0xFFFE, Z=0, C=0.
- Logic and conditional move:
  - xor R4,R4: Z=1, C=0.
  - Then mvnz R5,R6: R5 unchanged.
  - Then and giving 0x00F0: Z=0.
  - Then mvnz R5,R6: R5 = R6.
- Parametrisation: build with W=8, RBITS=2 (IRW=7). Run mvi R3=0xC8, mvi R1=0x64, add R3,R1: R3=0x2C, C=1; reserved opcode 111 writes nothing and Done is high in T1.
- Back-to-back: hold Run=1 across a stream of add, mv, sub. Required: no idle T0 cycles between instructions, and the total cycle count is 4+2+4.
